bcd_tick_counter: RTL and testbench

Decimal event counter that consumes the one-cycle strobe from the clock-divider stage and accumulates it as a packed multi-digit BCD value for the display path. A start/stop toggle and a synchronous clear control it through a three-state FSM. A registered wrap pulse flags roll-over for cascading or alarm logic.

---
 rtl/bcd_tick_counter.sv | 117 +++++++++++
 tb/tb_bcd_tick_counter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: packed multi-digit BCD event counter with IDLE/RUN/PAUSE control.
// Optional feature macro DOWN_COUNT_EN adds dir-selected down counting with borrow.
module bcd_tick_counter #(
   parameter int DIGITS = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                tick,
   input  logic                start_stop,
   input  logic                clear,
   input  logic                dir,
   output logic [4*DIGITS-1:0] count,
   output logic                running,
   output logic                wrap
);

   localparam int CW = 4 * DIGITS;

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] RUN   = 2'b01;
   localparam logic [1:0] PAUSE = 2'b10;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic        step_en;
   logic [CW:0] step_res;

   // Returns {roll-over, incremented value}; out-of-range digits behave as 9.
   function automatic logic [CW:0] bcd_inc(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic [3:0]    d;
      logic          c;
      c = 1'b1;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (c) begin
            if (d >= 4'd9) begin
               d = 4'd0;
            end else begin
               d = d + 4'd1;
               c = 1'b0;
            end
         end
         r[4*i +: 4] = d;
      end
      return {c, r};
   endfunction

`ifdef DOWN_COUNT_EN
   // Returns {roll-over, decremented value}; out-of-range digits behave as 0.
   function automatic logic [CW:0] bcd_dec(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic [3:0]    d;
      logic          b;
      b = 1'b1;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (b) begin
            if ((d == 4'd0) || (d > 4'd9)) begin
               d = 4'd9;
            end else begin
               d = d - 4'd1;
               b = 1'b0;
            end
         end
         r[4*i +: 4] = d;
      end
      return {b, r};
   endfunction

   assign step_res = dir ? bcd_dec(count) : bcd_inc(count);
`else
   logic unused_dir;
   assign unused_dir = dir;
   assign step_res   = bcd_inc(count);
`endif

   assign step_en = (state == RUN) && tick;

   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start_stop) state_nxt = RUN;
            RUN:     if (start_stop) state_nxt = PAUSE;
            PAUSE:   if (start_stop) state_nxt = RUN;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         running <= 1'b0;
         count   <= '0;
         wrap    <= 1'b0;
      end else begin
         state   <= state_nxt;
         running <= (state_nxt == RUN);
         if (clear) begin
            count <= '0;
            wrap  <= 1'b0;
         end else if (step_en) begin
            count <= step_res[CW-1:0];
            wrap  <= step_res[CW];
         end else begin
            wrap  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Scoreboard bench for bcd_tick_counter: integer reference model feeds an expectation queue.
`timescale 1ns/1ps
module tb_bcd_tick_counter;

   localparam int D    = 4;
   localparam int CW   = 4 * D;
   localparam int MAXV = 9999;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          tick = 1'b0;
   logic          start_stop = 1'b0;
   logic          clear = 1'b0;
   logic          dir = 1'b0;
   logic [CW-1:0] count;
   logic          running;
   logic          wrap;

   bcd_tick_counter #(.DIGITS(D)) dut (
      .clock      (clock),
      .reset      (reset),
      .tick       (tick),
      .start_stop (start_stop),
      .clear      (clear),
      .dir        (dir),
      .count      (count),
      .running    (running),
      .wrap       (wrap)
   );

   always #5 clock = ~clock;

   logic [CW+1:0] exp_q[$];
   logic [CW+1:0] mon_e;
   int            n_checks = 0;
   int            n_fail   = 0;

   int            m_cnt  = 0;
   int            m_mode = M_IDLE;
   logic          m_wrap = 1'b0;

   function automatic logic [CW-1:0] to_bcd(input int v);
      logic [CW-1:0] r;
      int            x;
      x = v;
      r = '0;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic model_step(input logic tk, input logic ss, input logic clr, input logic dr);
      logic down;
`ifdef DOWN_COUNT_EN
      down = dr;
`else
      down = 1'b0;
      if (dr === 1'bx) down = 1'b0;
`endif
      if (clr) begin
         m_cnt  = 0;
         m_mode = M_IDLE;
         m_wrap = 1'b0;
      end else begin
         m_wrap = 1'b0;
         if (m_mode == M_RUN && tk) begin
            if (down) begin
               if (m_cnt == 0) begin m_cnt = MAXV; m_wrap = 1'b1; end
               else m_cnt = m_cnt - 1;
            end else begin
               if (m_cnt == MAXV) begin m_cnt = 0; m_wrap = 1'b1; end
               else m_cnt = m_cnt + 1;
            end
         end
         if (ss) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
      end
   endtask

   task automatic cyc(input logic tk, input logic ss, input logic clr, input logic dr);
      @(negedge clock);
      reset      = 1'b1;
      tick       = tk;
      start_stop = ss;
      clear      = clr;
      dir        = dr;
      model_step(tk, ss, clr, dr);
      exp_q.push_back({to_bcd(m_cnt), (m_mode == M_RUN), m_wrap});
      @(posedge clock);
      #2;
   endtask

   task automatic rst_cyc();
      @(negedge clock);
      reset      = 1'b0;
      tick       = 1'($urandom_range(0, 1));
      start_stop = 1'($urandom_range(0, 1));
      clear      = 1'($urandom_range(0, 1));
      dir        = 1'($urandom_range(0, 1));
      m_cnt  = 0;
      m_mode = M_IDLE;
      m_wrap = 1'b0;
      exp_q.push_back({CW+2{1'b0}});
      @(posedge clock);
      #2;
   endtask

   task automatic chk(input string name, input logic [CW+1:0] want);
      n_checks++;
      if ({count, running, wrap} !== want) begin
         n_fail++;
         $display("FAIL %s: got count=%h running=%b wrap=%b, expected count=%h running=%b wrap=%b",
                  name, count, running, wrap, want[CW+1:2], want[1], want[0]);
      end
   endtask

   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if ({count, running, wrap} !== mon_e) begin
               n_fail++;
               $display("FAIL scoreboard t=%0t: got count=%h running=%b wrap=%b, expected count=%h running=%b wrap=%b",
                        $time, count, running, wrap, mon_e[CW+1:2], mon_e[1], mon_e[0]);
            end
         end
      end
   end

   initial begin
      #1 reset = 1'b0;
      repeat (4) rst_cyc();
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset_state", {16'h0000, 1'b0, 1'b0});

      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (12) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk("twelve_ticks", {16'h0012, 1'b1, 1'b0});

      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (9998) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("held_tick_9998", {16'h9998, 1'b1, 1'b0});
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("reach_9999", {16'h9999, 1'b1, 1'b0});
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("up_wrap", {16'h0000, 1'b1, 1'b1});
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("wrap_one_cycle", {16'h0000, 1'b1, 1'b0});

      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (41) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("reach_0041", {16'h0041, 1'b1, 1'b0});
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("tick_and_pause", {16'h0042, 1'b0, 1'b0});
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("paused_frozen", {16'h0042, 1'b0, 1'b0});

      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (300) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("pause_0300", {16'h0300, 1'b0, 1'b0});
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("clear_beats_tick", {16'h0000, 1'b0, 1'b0});

      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("dir_start_0001", {16'h0001, 1'b1, 1'b0});
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
`ifdef DOWN_COUNT_EN
      chk("down_to_0000", {16'h0000, 1'b1, 1'b0});
`else
      chk("dir_ignored_0002", {16'h0002, 1'b1, 1'b0});
`endif
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
`ifdef DOWN_COUNT_EN
      chk("down_wrap_9999", {16'h9999, 1'b1, 1'b1});
`else
      chk("dir_ignored_0003", {16'h0003, 1'b1, 1'b0});
`endif

      for (int i = 0; i < 3000; i++) begin
         if ((i % 700) == 350) begin
            rst_cyc();
         end else begin
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)));
         end
      end

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
         @(posedge clock);
         #2;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
